// File: rtl/sccb_target_regfile.sv
// SCCB/I2C target with a 256x8 register file.
// Oversamples the bus, drives SDA open-drain, strobes data writes.
module sccb_target_regfile #(
  parameter logic [6:0] DEV_ADDR    = 7'h21,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] reg_ptr,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, REG, REG_ACK,
    WDATA, WDATA_ACK, RDATA, RD_ACK, WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sy;
  logic [SYNC_STAGES-1:0] sda_sy;
  logic       scl_d;
  logic       sda_d;
  logic       scl_s;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;
  logic       start;
  logic       stop;

  state_t     state;
  logic [3:0] cnt;
  logic [7:0] sh;
  logic [7:0] sh_nx;
  logic       rw;
  logic       acked;
  logic [7:0] ptr_inc;
  logic [7:0] rd;
  logic [2:0] bidx;
  logic       mem_we;

  logic [7:0] mem [256];

  assign scl_s    = scl_sy[SYNC_STAGES-1];
  assign sda_s    = sda_sy[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = sda_d & ~sda_s & scl_s & scl_d;
  assign stop     = ~sda_d & sda_s & scl_s & scl_d;

  assign sh_nx   = {sh[6:0], sda_s};
  assign ptr_inc = reg_ptr + 8'd1;
  assign rd      = mem[reg_ptr];
  assign bidx    = ~cnt[2:0];
  assign busy    = (state != IDLE);
  assign mem_we  = (state == WDATA) & scl_rise
                 & (cnt == 4'd7);

  // Pad synchronizers plus one delay flop for edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_sy <= '1;
      sda_sy <= '1;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_sy <= {scl_sy[SYNC_STAGES-2:0], scl_in};
      sda_sy <= {sda_sy[SYNC_STAGES-2:0], sda_in};
      scl_d  <= scl_s;
      sda_d  <= sda_s;
    end
  end

  // Register file storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[reg_ptr] <= sh_nx;
  end

  // Bus protocol FSM with registered SDA drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      sh      <= 8'd0;
      rw      <= 1'b0;
      acked   <= 1'b0;
      sda_oe  <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= 8'd0;
      wr_data <= 8'd0;
      reg_ptr <= 8'd0;
    end else begin
      wr_stb <= 1'b0;
      if (start) begin
        state  <= DEV;
        cnt    <= 4'd0;
        sda_oe <= 1'b0;
        acked  <= 1'b0;
      end else if (stop) begin
        state  <= IDLE;
        cnt    <= 4'd0;
        sda_oe <= 1'b0;
        acked  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: ;
          DEV: begin
            if (scl_rise) begin
              sh  <= sh_nx;
              cnt <= cnt + 4'd1;
            end else if (scl_fall && cnt == 4'd8) begin
              cnt <= 4'd0;
              if (sh[7:1] == DEV_ADDR) begin
                sda_oe <= 1'b1;
                rw     <= sh[0];
                state  <= DEV_ACK;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          DEV_ACK: begin
            if (scl_fall) begin
              if (rw) begin
                sh     <= rd;
                sda_oe <= ~rd[7];
                cnt    <= 4'd1;
                state  <= RDATA;
              end else begin
                sda_oe <= 1'b0;
                cnt    <= 4'd0;
                state  <= REG;
              end
            end
          end
          REG: begin
            if (scl_rise) begin
              sh  <= sh_nx;
              cnt <= cnt + 4'd1;
            end else if (scl_fall && cnt == 4'd8) begin
              reg_ptr <= sh;
              sda_oe  <= 1'b1;
              cnt     <= 4'd0;
              state   <= REG_ACK;
            end
          end
          REG_ACK, WDATA_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              cnt    <= 4'd0;
              state  <= WDATA;
            end
          end
          WDATA: begin
            if (scl_rise) begin
              sh  <= sh_nx;
              cnt <= cnt + 4'd1;
              if (mem_we) begin
                wr_stb  <= 1'b1;
                wr_addr <= reg_ptr;
                wr_data <= sh_nx;
              end
            end else if (scl_fall && cnt == 4'd8) begin
              sda_oe  <= 1'b1;
              reg_ptr <= ptr_inc;
              cnt     <= 4'd0;
              state   <= WDATA_ACK;
            end
          end
          RDATA: begin
            if (scl_fall) begin
              if (cnt == 4'd8) begin
                sda_oe <= 1'b0;
                cnt    <= 4'd0;
                state  <= RD_ACK;
              end else begin
                sda_oe <= ~sh[bidx];
                cnt    <= cnt + 4'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              reg_ptr <= ptr_inc;
              if (!sda_s) begin
                sh    <= mem[ptr_inc];
                acked <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                state  <= WAIT_STOP;
              end
            end else if (scl_fall && acked) begin
              sda_oe <= ~sh[7];
              cnt    <= 4'd1;
              acked  <= 1'b0;
              state  <= RDATA;
            end
          end
          WAIT_STOP: sda_oe <= 1'b0;
          default: begin
            sda_oe <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
